// File: rtl/rgb_info_uart_tx.sv
// ---------------------------------------------------------------------------
// rgb_info_uart_tx
//   UART transmitter for the byte stream of the RGB info protocol engine.
//   Each accepted byte is sent LSB first as 8N1 on txd. If the macro
//   UART_TX_PARITY_EN is defined, an even parity bit is inserted before the
//   stop bit (8E1).
//
//   Handshake: the engine holds dataTxStart high until it sees dataTxActive.
//   It issues the next byte only when dataTxActive and dataTxDone are both
//   low.
//
// Parameters
//   CLKFreq   clock frequency in Hz (real)
//   BaudRate  line rate in bit/s
//
// Ports
//   clk           system clock, all logic on posedge
//   resetn        synchronous reset, active low
//   dataToTx      byte to send, sampled only when a frame is accepted
//   dataTxStart   transmit request (level), sampled only in IDLE
//   dataTxActive  high while a frame is in progress
//   dataTxDone    one-cycle pulse at the end of the stop bit
//   txd           serial line, idles at 1 (mark)
// ---------------------------------------------------------------------------
module rgb_info_uart_tx #(
   parameter real CLKFreq  = 27000000.0,
   parameter int  BaudRate = 115200
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] dataToTx,
   input  logic       dataTxStart,
   output logic       dataTxActive,
   output logic       dataTxDone,
   output logic       txd
);

   // Nearest whole number of clocks per bit.
   localparam int CYCLES_PER_BIT = $rtoi(CLKFreq / BaudRate + 0.5);
   localparam int BITS_BaudCnt   = $clog2(CYCLES_PER_BIT);
   localparam logic [BITS_BaudCnt-1:0] BAUD_LAST = BITS_BaudCnt'(CYCLES_PER_BIT - 1);

   if (CYCLES_PER_BIT < 2) begin : g_bad_baud
      $error("rgb_info_uart_tx: CLKFreq/BaudRate must give at least 2 clocks per bit");
   end

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]              state;
   logic [BITS_BaudCnt-1:0] baud_cnt;
   logic [2:0]              bit_idx;
   logic [7:0]              shreg;
   logic                    bit_end;
`ifdef UART_TX_PARITY_EN
   logic                    par_bit;
`endif

   assign bit_end = (baud_cnt == BAUD_LAST);

   // NOTE: all state is updated with non-blocking assignments so every
   // register sees the values from before the edge, regardless of the order
   // of the statements below.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and also clears the datapath registers
      // (shift register, counters), so a post-reset frame never depends on
      // leftovers from an aborted one.
      if (!resetn) begin
         state        <= IDLE;
         baud_cnt     <= '0;
         bit_idx      <= '0;
         shreg        <= '0;
         txd          <= 1'b1;
         dataTxActive <= 1'b0;
         dataTxDone   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_bit      <= 1'b0;
`endif
      end else begin
         dataTxDone <= 1'b0;

         // Free-running bit timer while a frame is in progress.
         if (state != IDLE) begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               txd          <= 1'b1;
               dataTxActive <= 1'b0;
               if (dataTxStart) begin
                  shreg        <= dataToTx;
                  txd          <= 1'b0;
                  dataTxActive <= 1'b1;
                  baud_cnt     <= '0;
                  bit_idx      <= '0;
                  state        <= START;
`ifdef UART_TX_PARITY_EN
                  par_bit      <= ^dataToTx;
`endif
               end
            end

            START: begin
               if (bit_end) begin
                  txd     <= shreg[0];
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end

            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     txd   <= par_bit;
                     state <= PARITY;
`else
                     txd   <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     // The next bit to send is the one moving into bit 0.
                     shreg   <= {1'b0, shreg[7:1]};
                     txd     <= shreg[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  txd   <= 1'b1;
                  state <= STOP;
               end
            end
`endif

            STOP: begin
               if (bit_end) begin
                  dataTxActive <= 1'b0;
                  dataTxDone   <= 1'b1;
                  state        <= IDLE;
               end
            end

            default: begin
               txd          <= 1'b1;
               dataTxActive <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_info_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_rgb_info_uart_tx
//   Self-checking bench for rgb_info_uart_tx at 10 clocks per bit.
//   Inputs are driven on the falling clock edge. Outputs are sampled on the
//   falling edge. An independent receiver decodes txd and compares each byte
//   against a scoreboard queue that is filled when a byte is requested.
// ---------------------------------------------------------------------------
module tb_rgb_info_uart_tx;

   localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME = FRAME_BITS * CPB;
   localparam int NVEC  = 11;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] dataToTx;
   logic       dataTxStart;
   logic       dataTxActive;
   logic       dataTxDone;
   logic       txd;

   always #5 clk = ~clk;

   rgb_info_uart_tx #(
      .CLKFreq (1000000.0),
      .BaudRate(100000)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .dataToTx    (dataToTx),
      .dataTxStart (dataTxStart),
      .dataTxActive(dataTxActive),
      .dataTxDone  (dataTxDone),
      .txd         (txd)
   );

   int n_checks  = 0;
   int n_errors  = 0;
   int done_cnt  = 0;
   int rx_frames = 0;
   logic [7:0] sb_q[$];

   typedef struct packed {
      logic [7:0] data;
      logic       exp_par;
   } vec_t;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected line level k clocks after the frame is accepted.
   function automatic logic exp_txd(input logic [7:0] b, input logic p, input int k);
      int idx;
      idx = k / CPB;
      if (idx == 0)      return 1'b0;
      else if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
      else if (idx == 9) return p;
`endif
      else               return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (dataTxDone === 1'b1) done_cnt++;
   end

   // Wait n falling edges. Stop early if reset is seen.
   task automatic rx_wait(input int n, inout logic ab);
      for (int j = 0; j < n && !ab; j++) begin
         @(negedge clk);
         if (resetn !== 1'b1) ab = 1'b1;
      end
   endtask

   // Independent receiver. It samples each bit in the middle of its period.
   initial begin : rx_monitor
      logic [7:0] rx;
      logic       ab;
      forever begin
         @(negedge clk);
         if (resetn === 1'b1 && txd === 1'b0) begin
            ab = 1'b0;
            rx = '0;
            rx_wait(CPB / 2, ab);
            if (!ab && txd === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  rx_wait(CPB, ab);
                  rx[i] = txd;
               end
`ifdef UART_TX_PARITY_EN
               rx_wait(CPB, ab);
               if (!ab) check("rx_parity", 32'(txd), 32'(^rx));
`endif
               rx_wait(CPB, ab);
               if (!ab) begin
                  check("rx_stop", 32'(txd), 32'd1);
                  rx_frames++;
                  if (sb_q.size() == 0) begin
                     n_checks++;
                     n_errors++;
                     $display("FAIL rx_unexpected: got byte %02h, no byte pending", rx);
                  end else begin
                     check("rx_byte", 32'(rx), 32'(sb_q.pop_front()));
                  end
               end
            end
         end
      end
   end

   // One protocol-engine transfer, checked cycle by cycle.
   // mod_at >= 0 : change dataToTx to mod_val k clocks into the frame.
   // rst_at >= 0 : assert resetn low k clocks into the frame (aborts it).
   task automatic send_byte(input logic [7:0] b, input logic p, input int mod_at,
                            input logic [7:0] mod_val, input int rst_at);
      int w;
      w = 0;
      while ((dataTxActive !== 1'b0 || dataTxDone !== 1'b0) && w < 2 * FRAME) begin
         @(negedge clk);
         w++;
      end
      check("engine_idle", 32'(dataTxActive | dataTxDone), 32'd0);

      dataToTx    = b;
      dataTxStart = 1'b1;
      sb_q.push_back(b);
      @(negedge clk);
      check("accept_latency", 32'(dataTxActive), 32'd1);
      dataTxStart = 1'b0;
      if (dataTxActive !== 1'b1) begin
         sb_q.delete();
         return;
      end

      for (int k = 0; k <= FRAME; k++) begin
         if (k > 0) @(negedge clk);
         if (rst_at >= 0 && k == rst_at + 1) begin
            check("abort_txd", 32'(txd), 32'd1);
            check("abort_active", 32'(dataTxActive), 32'd0);
            check("abort_done", 32'(dataTxDone), 32'd0);
            resetn = 1'b1;
            return;
         end
         if (k < FRAME) begin
            check($sformatf("txd@%0d", k), 32'(txd), 32'(exp_txd(b, p, k)));
            check($sformatf("active@%0d", k), 32'(dataTxActive), 32'd1);
            check($sformatf("done@%0d", k), 32'(dataTxDone), 32'd0);
         end else begin
            check("end_active", 32'(dataTxActive), 32'd0);
            check("end_done", 32'(dataTxDone), 32'd1);
            check("end_txd", 32'(txd), 32'd1);
         end
         if (k == mod_at) dataToTx = mod_val;
         if (k == rst_at) begin
            resetn = 1'b0;
            sb_q.delete();
         end
      end
      @(negedge clk);
      check("done_one_cycle", 32'(dataTxDone), 32'd0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int done_before;
      int frames_expected;

      vecs[0]  = '{data: 8'h55, exp_par: 1'b0};
      vecs[1]  = '{data: 8'h41, exp_par: 1'b0};   // 'A'
      vecs[2]  = '{data: 8'h43, exp_par: 1'b1};   // 'C'
      vecs[3]  = '{data: 8'h4B, exp_par: 1'b0};   // 'K'
      vecs[4]  = '{data: 8'h0D, exp_par: 1'b1};   // CR
      vecs[5]  = '{data: 8'h0A, exp_par: 1'b0};   // LF
      vecs[6]  = '{data: 8'h07, exp_par: 1'b1};
      vecs[7]  = '{data: 8'h03, exp_par: 1'b0};
      vecs[8]  = '{data: 8'h00, exp_par: 1'b0};
      vecs[9]  = '{data: 8'hFF, exp_par: 1'b0};
      vecs[10] = '{data: 8'h80, exp_par: 1'b1};
      frames_expected = 0;

      resetn      = 1'b0;
      dataTxStart = 1'b0;
      dataToTx    = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_active", 32'(dataTxActive), 32'd0);
      check("rst_done", 32'(dataTxDone), 32'd0);
      resetn = 1'b1;
      repeat (50) @(negedge clk);
      check("idle_txd", 32'(txd), 32'd1);
      check("idle_active", 32'(dataTxActive), 32'd0);
      check("idle_done_count", 32'(done_cnt), 32'd0);

      // A request in the same cycle as reset is not accepted.
      resetn      = 1'b0;
      dataTxStart = 1'b1;
      dataToTx    = 8'h5A;
      @(negedge clk);
      check("rst_wins_active", 32'(dataTxActive), 32'd0);
      check("rst_wins_txd", 32'(txd), 32'd1);
      resetn      = 1'b1;
      dataTxStart = 1'b0;
      @(negedge clk);
      check("rst_wins_after", 32'(dataTxActive), 32'd0);

      // Table-driven frames, including "ACK",CR,LF sent back to back.
      done_before = done_cnt;
      for (int i = 0; i < NVEC; i++) begin
         send_byte(vecs[i].data, vecs[i].exp_par, -1, 8'h00, -1);
         frames_expected++;
      end
      check("table_done_pulses", 32'(done_cnt - done_before), 32'(NVEC));

      // Changing dataToTx mid-frame does not affect the byte on the line.
      send_byte(8'hA3, 1'b0, 20, 8'hFF, -1);
      frames_expected++;

      // Reset mid-frame aborts the frame without a done pulse.
      done_before = done_cnt;
      send_byte(8'h00, 1'b0, -1, 8'h00, 45);
      repeat (30) @(negedge clk);
      check("abort_no_done", 32'(done_cnt - done_before), 32'd0);
      check("abort_idle_txd", 32'(txd), 32'd1);
      check("abort_idle_active", 32'(dataTxActive), 32'd0);

      // The first frame after the abort is clean.
      send_byte(8'h3C, 1'b0, -1, 8'h00, -1);
      frames_expected++;

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      check("rx_frame_count", 32'(rx_frames), 32'(frames_expected));
      check("done_total", 32'(done_cnt), 32'(frames_expected));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
